adder_subtractor: RTL and testbench

ADDER_SUBTRACTOR -- requirements
Module: adder_subtractor

---
 rtl/adder_subtractor_pkg.sv | 9 +
 rtl/full_adder.sv | 16 +
 rtl/adder_subtractor.sv | 78 +++++++
 tb/tb_adder_subtractor.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/adder_subtractor_pkg.sv
// Shared constants for the adder/subtractor: mode encodings and default width.
package adder_subtractor_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder stage used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Combinational sum and carry of one bit position.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/adder_subtractor.sv
// Ripple-carry adder/subtractor with a single registered output stage.
// M selects add (A+B) or subtract (A+~B+1); results appear one cycle after sampling.
module adder_subtractor
    import adder_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             valid_q;

    // Subtract inverts B and injects the +1 as the stage-0 carry-in.
    always_comb begin
        is_sub   = (M == MODE_SUB);
        b_eff    = B ^ {WIDTH{is_sub}};
        carry[0] = is_sub;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Output register: capture on in_valid, otherwise hold; out_valid tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q    <= sum;
                cout_q <= carry[WIDTH];
                // Signed overflow: carry into MSB differs from carry out of MSB.
                ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
                zero_q <= (sum == '0);
            end
        end
    end

    // Drive outputs straight from the register stage.
    always_comb begin
        S         = s_q;
        cout      = cout_q;
        overflow  = ovf_q;
        zero      = zero_q;
        out_valid = valid_q;
    end

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed self-checking bench for adder_subtractor at WIDTH=4.
module tb_adder_subtractor;
    import adder_subtractor_pkg::*;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         out_valid;

    int checks;
    int errors;

    adder_subtractor #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .M         (m),
        .A         (a),
        .B         (b),
        .S         (s),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] es, input logic ec,
                             input logic eo, input logic ez, input logic ev);
        check({tag, ".S"}, 32'(s), 32'(es));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".ovf"}, 32'(overflow), 32'(eo));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    endtask

    // Present one operation with in_valid high, clock it, and check the result.
    task automatic run_op(input string tag, input logic mm, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
        in_valid = 1'b1;
        m        = mm;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #1;
        check_out(tag, es, ec, eo, ez, 1'b1);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        m        = MODE_ADD;
        a        = '0;
        b        = '0;

        #2;
        check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_clk", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // Back-to-back stream with in_valid held high throughout.
        run_op("add0", MODE_ADD, 4'b1010, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b0);
        run_op("add1", MODE_ADD, 4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
        run_op("add2", MODE_ADD, 4'b1100, 4'b0010, 4'b1110, 1'b0, 1'b0, 1'b0);
        run_op("add3", MODE_ADD, 4'b1111, 4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0);
        run_op("sub0", MODE_SUB, 4'b1010, 4'b0011, 4'b0111, 1'b1, 1'b1, 1'b0);
        run_op("sub1", MODE_SUB, 4'b0000, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
        run_op("sub2", MODE_SUB, 4'b1100, 4'b0010, 4'b1010, 1'b1, 1'b0, 1'b0);
        run_op("sub3", MODE_SUB, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1);
        run_op("add4", MODE_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 1'b0);

        // Idle cycles: inputs change but outputs must hold with out_valid low.
        in_valid = 1'b0;
        m        = MODE_SUB;
        a        = 4'b0011;
        b        = 4'b0011;
        @(posedge clk);
        #1;
        check_out("idle0", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        a = 4'b1111;
        b = 4'b0001;
        @(posedge clk);
        #1;
        check_out("idle1", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Resume after a bubble: 1001 - 0001 = 1000, no borrow, no overflow.
        run_op("resume", MODE_SUB, 4'b1001, 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0);

        // Reset pulsed between edges while an operation is presented.
        run_op("pre_rst", MODE_ADD, 4'b0110, 4'b0110, 4'b1100, 1'b0, 1'b1, 1'b0);
        m = MODE_ADD;
        a = 4'b0001;
        b = 4'b0010;
        #1;
        rst = 1'b1;
        #1;
        check_out("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        check_out("post_rel", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("after_rst", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);

        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out("final_idle", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
